// File: rtl/bitfusion_pkg.sv
// ============================================================================
//  Module      : bitfusion_pkg
//  Description : Shared BitFusion definitions. Holds the OBUF write-back state
//                encoding and the default array geometry, used by the control
//                unit and the output write-back path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bitfusion_pkg;

    localparam int DEFAULT_ARRAY_SIZE = 4;
    localparam int DEFAULT_DATA_W     = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } obuf_state_t;

    // Index width that never collapses to zero bits (a 1x1 array still needs
    // a one-bit index signal).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/obuf_col_capture.sv
// ============================================================================
//  Module      : obuf_col_capture
//  Description : One OBUF column. Stores the partial sums leaving the bottom
//                PE of its column in arrival order (row 0 first), tracks how
//                many rows have arrived, and flags any extra valid seen once
//                the column is full. Provides a read port for write-back.
//  Ports       : clk, RST        - clock, async active-high reset
//                clear           - restart the column (counter, overflow)
//                capture_en      - high only while the top is in CAPTURE
//                psum_valid/in   - column data stream
//                rd_row/rd_data  - read port (forwards a same-cycle store)
//                full_next       - column is full after this clock edge
//                overflow        - sticky extra-valid flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obuf_col_capture
    import bitfusion_pkg::*;
#(
    parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int ROW_W      = idx_w(ARRAY_SIZE)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              clear,
    input  logic              capture_en,
    input  logic              psum_valid,
    input  logic [DATA_W-1:0] psum_in,
    input  logic [ROW_W-1:0]  rd_row,
    output logic [DATA_W-1:0] rd_data,
    output logic              full_next,
    output logic              overflow
);

    localparam int CNT_W = $clog2(ARRAY_SIZE) + 1;

    logic [CNT_W-1:0]  r_row_cnt;
    logic [DATA_W-1:0] r_entries [ARRAY_SIZE];
    logic              w_full;
    logic              w_store;

    assign w_full  = (r_row_cnt == CNT_W'(ARRAY_SIZE));
    assign w_store = capture_en && psum_valid && !w_full;

    // The top registers write data from the next write index; forwarding the
    // entry being stored this cycle keeps that path correct even when the
    // final capture and the first read coincide.
    assign rd_data = (w_store && (r_row_cnt[ROW_W-1:0] == rd_row))
                   ? psum_in : r_entries[rd_row];

    assign full_next = w_full ||
                       (w_store && (r_row_cnt == CNT_W'(ARRAY_SIZE - 1)));

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_row_cnt <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                r_entries[i] <= '0;
            end
        end else if (clear) begin
            r_row_cnt <= '0;
            overflow  <= 1'b0;
        end else if (capture_en && psum_valid) begin
            if (w_full) begin
                overflow <= 1'b1;
            end else begin
                r_entries[r_row_cnt[ROW_W-1:0]] <= psum_in;
                r_row_cnt <= r_row_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/obuf_writeback.sv
// ============================================================================
//  Module      : obuf_writeback
//  Description : Captures the skewed partial-sum stream of the PE array into
//                the OBUF (one column capture unit per PE column), then writes
//                the ARRAY_SIZE x ARRAY_SIZE tile to data memory row-major.
//  Ports       : clk, RST                 - clock, async active-high reset
//                start, output_base_addr  - tile launch and base word address
//                psum_in, psum_valid      - per-column partial-sum stream
//                mem_wait                 - memory stall
//                mem_addr, mem_wr_data,
//                mem_wr_en                - registered memory write port
//                busy, done, capture_err  - status
//  Build macro : OBUF_RELU_EN - clamp negative OBUF entries to 0 on write-back
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obuf_writeback
    import bitfusion_pkg::*;
#(
    parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
    parameter int DATA_W     = DEFAULT_DATA_W
) (
    input  logic                             clk,
    input  logic                             RST,
    input  logic                             start,
    input  logic [9:0]                       output_base_addr,
    input  logic [ARRAY_SIZE-1:0][DATA_W-1:0] psum_in,
    input  logic [ARRAY_SIZE-1:0]            psum_valid,
    input  logic                             mem_wait,
    output logic [31:0]                      mem_addr,
    output logic [31:0]                      mem_wr_data,
    output logic                             mem_wr_en,
    output logic                             busy,
    output logic                             done,
    output logic                             capture_err
);

    localparam int ROW_W  = idx_w(ARRAY_SIZE);
    localparam int K_W    = idx_w(ARRAY_SIZE * ARRAY_SIZE);
    localparam int LAST_K = ARRAY_SIZE * ARRAY_SIZE - 1;

    obuf_state_t       r_state;
    obuf_state_t       w_state_next;

    logic [9:0]        r_base;
    logic [K_W-1:0]    r_k;
    logic [K_W-1:0]    w_k_next;
    logic              w_wr_en_next;
    logic [31:0]       w_addr_next;
    logic [31:0]       w_data_next;

    logic              w_clear;
    logic              w_capture_en;
    logic              w_last_k;
    logic [ROW_W-1:0]  w_rd_row;
    logic [ROW_W-1:0]  w_rd_col;
    logic [DATA_W-1:0] w_sel;
    logic [31:0]       w_ext;

    logic [DATA_W-1:0]     w_col_data [ARRAY_SIZE];
    logic [ARRAY_SIZE-1:0] w_col_full_next;
    logic [ARRAY_SIZE-1:0] w_col_overflow;

    assign w_clear      = (r_state == IDLE) && start;
    assign w_capture_en = (r_state == CAPTURE);
    assign w_last_k     = (r_k == K_W'(LAST_K));

    // ------------------------------------------------------------------
    // Column capture units
    // ------------------------------------------------------------------
    generate
        for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
            obuf_col_capture #(
                .ARRAY_SIZE (ARRAY_SIZE),
                .DATA_W     (DATA_W),
                .ROW_W      (ROW_W)
            ) u_col (
                .clk        (clk),
                .RST        (RST),
                .clear      (w_clear),
                .capture_en (w_capture_en),
                .psum_valid (psum_valid[c]),
                .psum_in    (psum_in[c]),
                .rd_row     (w_rd_row),
                .rd_data    (w_col_data[c]),
                .full_next  (w_col_full_next[c]),
                .overflow   (w_col_overflow[c])
            );
        end
    endgenerate

    assign capture_err = |w_col_overflow;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start)                  w_state_next = CAPTURE;
            CAPTURE: if (&w_col_full_next)       w_state_next = WRITE;
            WRITE:   if (!mem_wait && w_last_k)  w_state_next = DONE;
            DONE:                                w_state_next = IDLE;
            default:                             w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. The memory port is registered, so the values
    // computed here are those presented in the cycle after the edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_k_next = r_k;
        unique case (r_state)
            CAPTURE: w_k_next = '0;
            WRITE:   if (!mem_wait && !w_last_k) w_k_next = r_k + 1'b1;
            default: w_k_next = r_k;
        endcase

        w_wr_en_next = (w_state_next == WRITE);
        w_rd_row     = ROW_W'(w_k_next / ARRAY_SIZE);
        w_rd_col     = ROW_W'(w_k_next % ARRAY_SIZE);
        w_sel        = w_col_data[w_rd_col];
        w_ext        = 32'($signed(w_sel));

        w_addr_next = '0;
        w_data_next = '0;
        if (w_wr_en_next) begin
            // Full 32-bit add so a tile near the top of the 10-bit base range
            // continues past 0x3FF rather than wrapping.
            w_addr_next = {22'd0, r_base} + 32'(w_k_next);
`ifdef OBUF_RELU_EN
            w_data_next = w_sel[DATA_W-1] ? 32'd0 : w_ext;
`else
            w_data_next = w_ext;
`endif
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_base      <= '0;
            r_k         <= '0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            if (w_clear) begin
                r_base <= output_base_addr;
            end
            r_k         <= w_k_next;
            mem_wr_en   <= w_wr_en_next;
            mem_addr    <= w_addr_next;
            mem_wr_data <= w_data_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_obuf_writeback.sv
// ============================================================================
//  Module      : tb_obuf_writeback
//  Description : Self-checking bench for obuf_writeback (ARRAY_SIZE=4,
//                DATA_W=32). Stimulus queues expected memory writes; a monitor
//                compares every presented write against the queue.
//  Build macro : OBUF_RELU_EN - expected write data follows the ReLU build
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obuf_writeback;

    localparam int AS = 4;
    localparam int DW = 32;

    logic                   clk;
    logic                   RST;
    logic                   start;
    logic [9:0]             output_base_addr;
    logic [AS-1:0][DW-1:0]  psum_in;
    logic [AS-1:0]          psum_valid;
    logic                   mem_wait;
    logic [31:0]            mem_addr;
    logic [31:0]            mem_wr_data;
    logic                   mem_wr_en;
    logic                   busy;
    logic                   done;
    logic                   capture_err;

    obuf_writeback #(.ARRAY_SIZE(AS), .DATA_W(DW)) dut (
        .clk              (clk),
        .RST              (RST),
        .start            (start),
        .output_base_addr (output_base_addr),
        .psum_in          (psum_in),
        .psum_valid       (psum_valid),
        .mem_wait         (mem_wait),
        .mem_addr         (mem_addr),
        .mem_wr_data      (mem_wr_data),
        .mem_wr_en        (mem_wr_en),
        .busy             (busy),
        .done             (done),
        .capture_err      (capture_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] m [AS][AS];
    int          n_checks      = 0;
    int          n_fail        = 0;
    int          wr_cycles     = 0;
    int          exp_wr_cycles = 16;
    logic        last_accept   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef OBUF_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tile(input logic [9:0] base);
        for (int k = 0; k < AS * AS; k++) begin
            exp_q.push_back('{addr: 32'(base) + 32'(k), data: relu(m[k / AS][k % AS])});
        end
    endtask

    task automatic start_tile(input logic [9:0] base);
        start            = 1'b1;
        output_base_addr = base;
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic capture_aligned();
        for (int r = 0; r < AS; r++) begin
            psum_valid = '1;
            for (int c = 0; c < AS; c++) psum_in[c] = m[r][c];
            tick();
        end
        psum_valid = '0;
        chk("first_write_latency", {31'd0, mem_wr_en}, 32'd1);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        tick();
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard monitor: samples on the falling edge.
    always @(negedge clk) begin
        if (!RST) begin
            if (!busy) wr_cycles = 0;
            if (mem_wr_en) begin
                wr_cycles++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wr_data);
                end else begin
                    chk("wr_addr", mem_addr, exp_q[0].addr);
                    chk("wr_data", mem_wr_data, exp_q[0].data);
                    if (!mem_wait) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_addr_zero", mem_addr, 32'd0);
                chk("idle_data_zero", mem_wr_data, 32'd0);
            end
            if (done) begin
                chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
                chk("done_write_cycles", 32'(wr_cycles), 32'(exp_wr_cycles));
                chk("done_after_last_accept", {31'd0, last_accept}, 32'd1);
            end
            last_accept = mem_wr_en && !mem_wait;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; start = 1'b0; output_base_addr = '0;
        psum_in = '0; psum_valid = '0; mem_wait = 1'b0;
        repeat (3) tick();
        #2 RST = 1'b0;
        tick();

        // Reset state
        chk("rst_wr_en",   {31'd0, mem_wr_en},   32'd0);
        chk("rst_addr",    mem_addr,             32'd0);
        chk("rst_data",    mem_wr_data,          32'd0);
        chk("rst_busy",    {31'd0, busy},        32'd0);
        chk("rst_done",    {31'd0, done},        32'd0);
        chk("rst_cap_err", {31'd0, capture_err}, 32'd0);

        // Valid in IDLE is ignored
        psum_valid = '1; psum_in = '1;
        tick();
        chk("idle_valid_busy",    {31'd0, busy},        32'd0);
        chk("idle_valid_cap_err", {31'd0, capture_err}, 32'd0);

        // 1: aligned capture, valid in the start cycle must be dropped
        for (int r = 0; r < AS; r++) for (int c = 0; c < AS; c++) m[r][c] = 32'(16 * r + c);
        push_tile(10'h040);
        exp_wr_cycles = 16;
        psum_in = {4{32'hDEAD_BEEF}};
        start_tile(10'h040);
        capture_aligned();
        wait_done(40);
        chk("aligned_cap_err", {31'd0, capture_err}, 32'd0);

        // 2: skewed capture, column c valid in cycles c..c+3
        for (int r = 0; r < AS; r++) for (int c = 0; c < AS; c++) m[r][c] = 32'(100 + r);
        push_tile(10'h100);
        start_tile(10'h100);
        for (int t = 0; t < 7; t++) begin
            psum_valid = '0;
            for (int c = 0; c < AS; c++) begin
                if (t >= c && t <= c + 3) begin
                    psum_valid[c] = 1'b1;
                    psum_in[c]    = 32'(100 + t - c);
                end
            end
            tick();
            if (t == 5) chk("skew_no_early_write", {31'd0, mem_wr_en}, 32'd0);
        end
        psum_valid = '0;
        chk("skew_first_write", {31'd0, mem_wr_en}, 32'd1);
        wait_done(40);

        // 3: three stall cycles at k=5
        for (int r = 0; r < AS; r++) for (int c = 0; c < AS; c++) m[r][c] = 32'hF000_0000 | 32'(4 * r + c);
        push_tile(10'h080);
        exp_wr_cycles = 19;
        start_tile(10'h080);
        capture_aligned();
        repeat (5) tick();
        mem_wait = 1'b1;
        chk("stall_addr_k5", mem_addr, 32'h085);
        repeat (3) tick();
        mem_wait = 1'b0;
        chk("stall_addr_held", mem_addr, 32'h085);
        wait_done(40);
        exp_wr_cycles = 16;

        // 4: overflow on column 2, start during WRITE ignored
        for (int r = 0; r < AS; r++) for (int c = 0; c < AS; c++) m[r][c] = 32'(200 + 4 * r + c);
        push_tile(10'h010);
        start_tile(10'h010);
        for (int r = 0; r < AS; r++) begin
            psum_valid = 4'b0111;
            for (int c = 0; c < 3; c++) psum_in[c] = m[r][c];
            tick();
        end
        psum_valid = 4'b1100;
        psum_in[2] = 32'd999;
        psum_in[3] = m[0][3];
        tick();
        chk("overflow_cap_err", {31'd0, capture_err}, 32'd1);
        for (int r = 1; r < AS; r++) begin
            psum_valid = 4'b1000;
            psum_in[3] = m[r][3];
            tick();
        end
        psum_valid = '0;
        repeat (2) tick();
        start = 1'b1; output_base_addr = 10'h123;
        tick();
        start = 1'b0;
        wait_done(40);
        chk("cap_err_sticky", {31'd0, capture_err}, 32'd1);

        // 5: reset mid-WRITE at k=7, then a tile crossing 0x3FF
        for (int r = 0; r < AS; r++) for (int c = 0; c < AS; c++) m[r][c] = 32'h1234_0000 + 32'(4 * r + c);
        push_tile(10'h200);
        start_tile(10'h200);
        chk("start_clears_cap_err", {31'd0, capture_err}, 32'd0);
        capture_aligned();
        repeat (7) tick();
        chk("pre_reset_addr_k7", mem_addr, 32'h207);
        RST = 1'b1;
        exp_q.delete();
        #1;
        chk("reset_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("reset_busy",  {31'd0, busy},      32'd0);
        #1 RST = 1'b0;
        tick();
        push_tile(10'h3FC);
        start_tile(10'h3FC);
        capture_aligned();
        chk("nowrap_first_addr", mem_addr, 32'h3FC);
        wait_done(40);

        // 6: negative entries (ReLU build clamps them)
        for (int r = 0; r < AS; r++)
            for (int c = 0; c < AS; c++)
                m[r][c] = ((r + c) % 2 == 1) ? -32'(4 * r + c) : 32'(4 * r + c);
        m[0][0] = -32'd5;
        m[0][1] = 32'd7;
        push_tile(10'h300);
        start_tile(10'h300);
        capture_aligned();
`ifdef OBUF_RELU_EN
        chk("relu_neg5", mem_wr_data, 32'd0);
`else
        chk("raw_neg5", mem_wr_data, 32'hFFFF_FFFB);
`endif
        wait_done(40);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
